// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS mult/multu/div/divu sequencer that drives the shared 32-bit ALU
// one add/subtract per cycle and accumulates the result in HI/LO.
module muldiv_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_f,
  input  logic [31:0] alu_y
);

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_ADD  = 3'b010;
  localparam logic [2:0] F_SUB  = 3'b110;
  localparam logic [2:0] F_ORN  = 3'b101;
  localparam logic [4:0] LAST   = 5'(ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t      state_q;
  logic        div_q, sa_q, sb_q, lz_q, busy_q, done_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic [4:0]  cnt_q;

  logic [31:0] rem;
  logic        neg_res, carry, nborrow, qbit;

  assign neg_res = sa_q ^ sb_q;
  assign rem     = {hi_q[30:0], lo_q[31]};

  // Carry / not-borrow rebuilt from operand and result sign bits; ALU carry-out is unused.
  assign carry   = (alu_a[31] & alu_b[31]) | ((alu_a[31] | alu_b[31]) & ~alu_y[31]);
  assign nborrow = ~((~alu_a[31] & alu_b[31]) | (~(alu_a[31] ^ alu_b[31]) & alu_y[31]));
  assign qbit    = hi_q[31] | nborrow;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_f = F_NONE;
    case (state_q)
      S_NEG_A: begin alu_f = F_SUB; alu_b = a_q; end
      S_NEG_B: begin alu_f = F_SUB; alu_b = b_q; end
      S_ITER: begin
        if (div_q) begin
          alu_f = F_SUB; alu_a = rem; alu_b = b_q;
        end else begin
          alu_f = F_ADD; alu_a = hi_q; alu_b = lo_q[0] ? b_q : '0;
        end
      end
      S_FIX_LO: if (neg_res) begin alu_f = F_SUB; alu_b = lo_q; end
      S_FIX_HI: begin
        if (!div_q && neg_res) begin
          alu_f = lz_q ? F_SUB : F_ORN; alu_b = hi_q;
        end else if (div_q && sa_q) begin
          alu_f = F_SUB; alu_b = hi_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      lz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            div_q   <= op[1];
            sa_q    <= ~op[0] & srca[31];
            sb_q    <= ~op[0] & srcb[31];
            a_q     <= srca;
            b_q     <= srcb;
            busy_q  <= 1'b1;
            state_q <= S_NEG_A;
          end
        end
        S_NEG_A: begin
          if (sa_q) a_q <= alu_y;
          state_q <= S_NEG_B;
        end
        // Loop init: LO holds the shifted operand, b_q becomes multiplicand or divisor.
        S_NEG_B: begin
          hi_q  <= '0;
          cnt_q <= '0;
          if (div_q) begin
            lo_q <= a_q;
            b_q  <= sb_q ? alu_y : b_q;
          end else begin
            lo_q <= sb_q ? alu_y : b_q;
            b_q  <= a_q;
          end
          state_q <= S_ITER;
        end
        S_ITER: begin
          if (div_q) begin
            hi_q <= qbit ? alu_y : rem;
            lo_q <= {lo_q[30:0], qbit};
          end else begin
            hi_q <= {carry, alu_y[31:1]};
            lo_q <= {alu_y[0], lo_q[31:1]};
          end
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LAST) state_q <= S_FIX_LO;
        end
        S_FIX_LO: begin
          lz_q <= (lo_q == '0);
          if (neg_res) lo_q <= alu_y;
          state_q <= S_FIX_HI;
        end
        S_FIX_HI: begin
          if ((!div_q && neg_res) || (div_q && sa_q)) hi_q <= alu_y;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a behavioural ALU model and hand-computed results.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] srca, srcb;
  logic        busy, done;
  logic [31:0] hi, lo, alu_a, alu_b, alu_y;
  logic [2:0]  alu_f;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  muldiv_sequencer #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .srca(srca), .srcb(srcb), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .alu_y(alu_y)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_f)
      3'b000:  alu_y = alu_a & alu_b;
      3'b010:  alu_y = alu_a + alu_b;
      3'b110:  alu_y = alu_a - alu_b;
      3'b101:  alu_y = alu_a | ~alu_b;
      default: alu_y = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; srca = a; srcb = b;
    step();
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic finish_op(input string tag, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input int glitch);
    int low_busy = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy !== 1'b1) low_busy++;
      if (cyc == glitch) begin
        start = 1'b1; op = 2'b11; srca = 32'd1234; srcb = 32'd5;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    check({tag, " done_cycle"}, 32'(cyc), 32'd37);
    check({tag, " busy_at_done"}, {31'b0, busy}, 32'd1);
    check({tag, " busy_gaps"}, 32'(low_busy), 32'd0);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
    step();
    check({tag, " idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, " idle_done"}, {31'b0, done}, 32'd0);
    check({tag, " idle_alu_f"}, {29'b0, alu_f}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
    step();
    step();
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst done", {31'b0, done}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst alu_b", alu_b, 32'd0);
    check("rst alu_f", {29'b0, alu_f}, 32'd0);
    reset = 1'b0;
    step();

    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("nega alu_f", {29'b0, alu_f}, 32'b110);
    check("nega alu_a", alu_a, 32'd0);
    check("nega alu_b", alu_b, 32'hFFFF_FFFF);
    finish_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, -1);

    launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
    finish_op("mult_neg3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1);

    launch(2'b00, 32'h8000_0000, 32'h0000_0002);
    finish_op("mult_lz", 32'hFFFF_FFFF, 32'h0000_0000, -1);

    launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    finish_op("div_neg7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);

    launch(2'b11, 32'h0000_0064, 32'h0000_0007);
    finish_op("divu_glitch", 32'h0000_0002, 32'h0000_000E, 10);

    launch(2'b11, 32'h0000_0064, 32'h0000_0000);
    finish_op("divu_by0", 32'h0000_0064, 32'hFFFF_FFFF, -1);

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 32'h0000_0000, 32'h8000_0000, -1);

    launch(2'b01, 32'h1234_5678, 32'h0000_0009);
    while (cyc < 20) begin
      step();
      cyc++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst done", {31'b0, done}, 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    check("midrst alu_f", {29'b0, alu_f}, 32'd0);

    reset = 1'b1; start = 1'b1; op = 2'b01; srca = 32'd5; srcb = 32'd5;
    step();
    reset = 1'b0; start = 1'b0;
    check("rst_start busy0", {31'b0, busy}, 32'd0);
    step();
    check("rst_start busy1", {31'b0, busy}, 32'd0);

    launch(2'b01, 32'h0001_0000, 32'h0001_0000);
    finish_op("multu_after_rst", 32'h0000_0001, 32'h0000_0000, -1);
    step();
    step();
    check("hold hi", hi, 32'h0000_0001);
    check("hold lo", lo, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
